dma_bus_arbiter: RTL and testbench
==================================

# dma_bus_arbiter

CPU-side bus-ownership responder for the DMA engine. It accepts the DMA bus request, lets any in-flight CPU memory access finish, grants the memory bus to the DMA engine, and muxes the memory address bus to match. It reclaims the bus when the request drops or a watchdog expires, and latches the DMA-end pulse into a CPU interrupt that stays high until acknowledged. Sits between CPU datapath, DMA controller and memory.

## Interface
Parameters:
- WORD_SIZE, 16, address/data width
- MAX_GRANT_CYCLES, 64, watchdog limit on consecutive GRANT cycles (≥2)

Ports:
- clk  in  1  system clock, all state on posedge
- reset_n  in  1  asynchronous, active-low reset
- BR_from_dma  in  1  level bus request from DMA controller
- BG_to_dma  out  1  registered bus grant
- cpu_mem_req  in  1  CPU has a memory access in flight; held high until Mem_access_done
- Mem_access_done  in  1  one-cycle completion pulse from memory
- cpu_stall  out  1  CPU must not start a new memory access
- cpu_address  in  WORD_SIZE  CPU-driven memory address
- dma_address  in  WORD_SIZE  DMA-driven memory address
- address_to_mem  out  WORD_SIZE  muxed address to memory
- dma_end_interrupt  in  1  DMA completion pulse, may be several cycles wide
- interrupt_to_cpu  out  1  latched DMA-done interrupt
- interrupt_ack  in  1  CPU acknowledge, one cycle
- grant_timeout  out  1  one-cycle pulse when the watchdog reclaims the bus

## Operation
- FSM states: IDLE, DRAIN, GRANT, RELEASE. Reset state is IDLE.
- IDLE
  - BR=1, cpu_mem_req=0 → GRANT.
  - BR=1, cpu_mem_req=1 → DRAIN.
  - Otherwise stay in IDLE.
- DRAIN
  - Mem_access_done=1 → GRANT.
  - BR=0 (and no done) → IDLE.
  - Done has priority over BR drop.
- GRANT
  - BR=0 → RELEASE.
  - Watchdog count reaches MAX_GRANT_CYCLES → RELEASE, pulse grant_timeout, set blocked.
- RELEASE: lasts exactly one cycle, then → IDLE. It never re-grants directly.
- blocked flag
  - While set, IDLE ignores BR.
  - Clears when BR_from_dma is sampled 0.
- BG_to_dma is a registered output: it is 1 exactly while state==GRANT.
- cpu_stall (combinational) = BR_from_dma | (state≠IDLE).
- address_to_mem (combinational) = BG_to_dma ? dma_address : cpu_address. It is never high-Z.
- Watchdog counter
  - Width is $clog2(MAX_GRANT_CYCLES+1).
  - Clears on GRANT entry and increments each GRANT cycle.
  - The comparison happens before the increment, so the maximum grant length is exactly MAX_GRANT_CYCLES cycles.
- Interrupt latch
  - A registered rising-edge detect on dma_end_interrupt sets interrupt_to_cpu.
  - interrupt_ack clears it.
  - If set and ack occur in the same cycle, set wins.
  - A wide pulse sets the latch only once.

## Timing
- Reset values: BG_to_dma=0, interrupt_to_cpu=0, grant_timeout=0, counter=0, blocked=0, edge-detect register=0.
- With reset asserted:
  - cpu_stall follows BR_from_dma.
  - address_to_mem = cpu_address.
- Reset mid-grant drops BG_to_dma immediately, without waiting for clk.
- Grant latency with an idle CPU: BR sampled high at edge N → BG_to_dma=1 after edge N.
- Grant latency with CPU busy: BG_to_dma=1 after the edge that samples Mem_access_done.
- Release latency: BR sampled low at edge N → BG_to_dma=0 after edge N. cpu_stall stays 1 for one more cycle (RELEASE).
- Interrupt latency: interrupt_to_cpu=1 one cycle after the dma_end_interrupt rising edge is sampled.
- Back-to-back request: the earliest possible re-grant is 2 cycles after release (RELEASE, then IDLE).

## Structure
- Shared package holds:
  - WORD_SIZE define (16)
  - 2-bit state encoding: IDLE=0, DRAIN=1, GRANT=2, RELEASE=3
- One sub-module, irq_latch, contains the edge detect, set/ack logic and set-wins priority.
- The FSM, watchdog, blocked flag and muxes stay in the top module.

## Test plan
- Idle CPU: BR=1 at cycle 5 → BG=1 from cycle 6, address_to_mem=dma_address (0x0200). BR=0 at cycle 12 → BG=0 at cycle 13, cpu_stall=0 at cycle 14.
- Busy CPU: cpu_mem_req=1, BR=1, Mem_access_done at cycle 8 → BG=0 through cycle 8, BG=1 at cycle 9. address_to_mem=cpu_address (0x0040) until then.
- Watchdog with MAX_GRANT_CYCLES=4 and BR held high → BG high exactly 4 cycles, then one grant_timeout pulse. No re-grant until BR=0 for one cycle, then BR=1 again.
- 3-cycle dma_end_interrupt pulse → interrupt_to_cpu=1 once; ack clears it. A new rising edge in the same cycle as ack → interrupt stays 1.
- reset_n=0 during GRANT → BG=0 and interrupt_to_cpu=0 asynchronously; after release, state is IDLE.
- BR drops while in DRAIN with no done → return to IDLE, BG never asserted, cpu_stall=0 the following cycle.

Source files
------------

// File: rtl/dma_bus_arbiter_pkg.sv
// Shared definitions for the DMA bus arbiter: default bus width and FSM state encoding.
package dma_bus_arbiter_pkg;

   localparam int WORD_SIZE_DEFAULT = 16;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_DRAIN   = 2'd1,
      ST_GRANT   = 2'd2,
      ST_RELEASE = 2'd3
   } arb_state_t;

endpackage

// File: rtl/dma_bus_arbiter_if.sv
// Bundle of CPU / DMA / memory handshake signals around the bus arbiter.
interface dma_bus_arbiter_if
   import dma_bus_arbiter_pkg::*;
#(
   parameter int WORD_SIZE = WORD_SIZE_DEFAULT
);

   logic                 BR_from_dma;
   logic                 BG_to_dma;
   logic                 cpu_mem_req;
   logic                 Mem_access_done;
   logic                 cpu_stall;
   logic [WORD_SIZE-1:0] cpu_address;
   logic [WORD_SIZE-1:0] dma_address;
   logic [WORD_SIZE-1:0] address_to_mem;
   logic                 dma_end_interrupt;
   logic                 interrupt_to_cpu;
   logic                 interrupt_ack;
   logic                 grant_timeout;

   modport slave (
      input  BR_from_dma, cpu_mem_req, Mem_access_done, cpu_address, dma_address,
             dma_end_interrupt, interrupt_ack,
      output BG_to_dma, cpu_stall, address_to_mem, interrupt_to_cpu, grant_timeout
   );

   modport master (
      output BR_from_dma, cpu_mem_req, Mem_access_done, cpu_address, dma_address,
             dma_end_interrupt, interrupt_ack,
      input  BG_to_dma, cpu_stall, address_to_mem, interrupt_to_cpu, grant_timeout
   );

endinterface

// File: rtl/dma_bus_arbiter_irq_latch.sv
// DMA-done interrupt latch: rising-edge detect on the end pulse, cleared by CPU ack.
module dma_bus_arbiter_irq_latch
   import dma_bus_arbiter_pkg::*;
(
   input  logic clk,
   input  logic reset_n,
   input  logic dma_end_interrupt,
   input  logic interrupt_ack,
   output logic interrupt_to_cpu
);

   logic end_prev_q;
   logic irq_q;
   logic end_rise;

   assign end_rise = dma_end_interrupt & ~end_prev_q;

   // a new edge in the ack cycle must not be lost, so set outranks clear
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         end_prev_q <= 1'b0;
         irq_q      <= 1'b0;
      end else begin
         end_prev_q <= dma_end_interrupt;
         if (end_rise)
            irq_q <= 1'b1;
         else if (interrupt_ack)
            irq_q <= 1'b0;
      end
   end

   assign interrupt_to_cpu = irq_q;

endmodule

// File: rtl/dma_bus_arbiter.sv
// Hands the memory bus to the DMA engine once any CPU access drains, reclaims it on
// request drop or watchdog expiry, and muxes the memory address to the current owner.
//
// state   | meaning
// IDLE    | CPU owns the bus, watching for a DMA request
// DRAIN   | request pending, waiting for the in-flight CPU access to complete
// GRANT   | DMA owns the bus, watchdog running
// RELEASE | one-cycle turnaround back to the CPU
module dma_bus_arbiter
   import dma_bus_arbiter_pkg::*;
#(
   parameter int WORD_SIZE        = WORD_SIZE_DEFAULT,
   parameter int MAX_GRANT_CYCLES = 64
) (
   input logic              clk,
   input logic              reset_n,
   dma_bus_arbiter_if.slave bus
);

   localparam int              WD_W    = $clog2(MAX_GRANT_CYCLES + 1);
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(MAX_GRANT_CYCLES - 1);

   arb_state_t           state_q;
   arb_state_t           state_d;
   logic                 bg_q;
   logic                 timeout_q;
   logic                 blocked_q;
   logic                 blocked_d;
   logic                 wd_expire;
   logic [WD_W-1:0]      wd_cnt_q;
   logic [WORD_SIZE-1:0] addr_mux;
   logic                 irq;

   always_comb begin
      state_d   = state_q;
      wd_expire = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (bus.BR_from_dma && !blocked_q)
               state_d = bus.cpu_mem_req ? ST_DRAIN : ST_GRANT;
         end
         ST_DRAIN: begin
            if (bus.Mem_access_done)
               state_d = ST_GRANT;
            else if (!bus.BR_from_dma)
               state_d = ST_IDLE;
         end
         ST_GRANT: begin
            if (!bus.BR_from_dma) begin
               state_d = ST_RELEASE;
            end else if (wd_cnt_q == WD_LAST) begin
               // count is checked before it advances, so this is the last granted cycle
               state_d   = ST_RELEASE;
               wd_expire = 1'b1;
            end
         end
         ST_RELEASE: state_d = ST_IDLE;
         default:    state_d = ST_IDLE;
      endcase

      blocked_d = blocked_q;
      if (wd_expire)
         blocked_d = 1'b1;
      else if (!bus.BR_from_dma)
         blocked_d = 1'b0;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= ST_IDLE;
         bg_q      <= 1'b0;
         timeout_q <= 1'b0;
         blocked_q <= 1'b0;
         wd_cnt_q  <= '0;
      end else begin
         state_q   <= state_d;
         bg_q      <= (state_d == ST_GRANT);
         timeout_q <= wd_expire;
         blocked_q <= blocked_d;
         if (state_d == ST_GRANT && state_q != ST_GRANT)
            wd_cnt_q <= '0;
         else if (state_q == ST_GRANT)
            wd_cnt_q <= wd_cnt_q + WD_W'(1);
      end
   end

   dma_bus_arbiter_irq_latch u_irq_latch (
      .clk               (clk),
      .reset_n           (reset_n),
      .dma_end_interrupt (bus.dma_end_interrupt),
      .interrupt_ack     (bus.interrupt_ack),
      .interrupt_to_cpu  (irq)
   );

   assign addr_mux             = bg_q ? bus.dma_address : bus.cpu_address;
   assign bus.address_to_mem   = addr_mux;
   assign bus.BG_to_dma        = bg_q;
   assign bus.cpu_stall        = bus.BR_from_dma | (state_q != ST_IDLE);
   assign bus.grant_timeout    = timeout_q;
   assign bus.interrupt_to_cpu = irq;

endmodule

// File: tb/tb_dma_bus_arbiter.sv
// Self-checking bench for dma_bus_arbiter: directed vector table, hand-written corner
// sequences and randomized traffic against a bus-ownership reference model.
module tb_dma_bus_arbiter;
   import dma_bus_arbiter_pkg::*;

   localparam int W    = 16;
   localparam int MAXG = 4;

   logic clk = 1'b0;
   logic reset_n;
   always #5 clk = ~clk;

   dma_bus_arbiter_if #(.WORD_SIZE(W)) bus ();

   dma_bus_arbiter #(.WORD_SIZE(W), .MAX_GRANT_CYCLES(MAXG)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus.slave)
   );

   int n_tests = 0;
   int n_fail  = 0;

   // reference model: who owns the bus and for how long
   bit m_granted, m_draining, m_releasing, m_blocked, m_timeout, m_irq, m_prev_end;
   int m_len;

   typedef struct {
      bit br, req, done, endi, ack;
      bit bg, stall, irq, to;
      logic [W-1:0] addr;
   } vec_t;

   vec_t vecs[21];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      m_granted = 0; m_draining = 0; m_releasing = 0; m_blocked = 0;
      m_timeout = 0; m_irq = 0; m_prev_end = 0; m_len = 0;
   endtask

   task automatic model_step(input bit br, req, done, endi, ack);
      bit old_blocked, expired;
      old_blocked = m_blocked;
      expired     = 0;
      if (endi && !m_prev_end) m_irq = 1;
      else if (ack)            m_irq = 0;
      m_prev_end = endi;
      if (m_releasing) begin
         m_releasing = 0;
      end else if (m_granted) begin
         if (!br) begin
            m_granted = 0; m_releasing = 1;
         end else if (m_len == MAXG) begin
            m_granted = 0; m_releasing = 1; expired = 1;
         end else begin
            m_len++;
         end
      end else if (m_draining) begin
         if (done) begin
            m_draining = 0; m_granted = 1; m_len = 1;
         end else if (!br) begin
            m_draining = 0;
         end
      end else if (br && !old_blocked) begin
         if (req) m_draining = 1;
         else begin m_granted = 1; m_len = 1; end
      end
      m_timeout = expired;
      if (expired)  m_blocked = 1;
      else if (!br) m_blocked = 0;
   endtask

   task automatic check_model(input string tag);
      logic [W-1:0] exp_addr;
      bit           exp_stall;
      exp_addr  = m_granted ? bus.dma_address : bus.cpu_address;
      exp_stall = bus.BR_from_dma | m_granted | m_draining | m_releasing;
      check({tag, " bg"},    32'(bus.BG_to_dma),        32'(m_granted));
      check({tag, " stall"}, 32'(bus.cpu_stall),        32'(exp_stall));
      check({tag, " addr"},  32'(bus.address_to_mem),   32'(exp_addr));
      check({tag, " irq"},   32'(bus.interrupt_to_cpu), 32'(m_irq));
      check({tag, " tmo"},   32'(bus.grant_timeout),    32'(m_timeout));
   endtask

   // called at a negedge: drive, clock once, compare at the next negedge
   task automatic step(input string tag, input bit br, req, done, endi, ack,
                       input logic [W-1:0] ca, input logic [W-1:0] da);
      bus.BR_from_dma       = br;
      bus.cpu_mem_req       = req;
      bus.Mem_access_done   = done;
      bus.dma_end_interrupt = endi;
      bus.interrupt_ack     = ack;
      bus.cpu_address       = ca;
      bus.dma_address       = da;
      @(posedge clk);
      model_step(br, req, done, endi, ack);
      @(negedge clk);
      check_model(tag);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish, got running expected done");
      $fatal(1, "timeout");
   end

   initial begin
      int bg_cnt, to_cnt;
      vecs = '{
         '{0,0,0,0,0, 0,0,0,0, 16'h0040},
         '{1,0,0,0,0, 1,1,0,0, 16'h0200},
         '{1,0,0,0,0, 1,1,0,0, 16'h0200},
         '{0,0,0,0,0, 0,1,0,0, 16'h0040},
         '{0,0,0,0,0, 0,0,0,0, 16'h0040},
         '{1,1,0,0,0, 0,1,0,0, 16'h0040},
         '{1,1,0,0,0, 0,1,0,0, 16'h0040},
         '{1,1,1,0,0, 1,1,0,0, 16'h0200},
         '{1,0,0,0,0, 1,1,0,0, 16'h0200},
         '{0,0,0,0,0, 0,1,0,0, 16'h0040},
         '{0,0,0,1,0, 0,0,1,0, 16'h0040},
         '{0,0,0,1,0, 0,0,1,0, 16'h0040},
         '{0,0,0,1,1, 0,0,0,0, 16'h0040},
         '{0,0,0,0,0, 0,0,0,0, 16'h0040},
         '{0,0,0,1,0, 0,0,1,0, 16'h0040},
         '{0,0,0,0,1, 0,0,0,0, 16'h0040},
         '{0,0,0,1,1, 0,0,1,0, 16'h0040},
         '{0,0,0,0,0, 0,0,1,0, 16'h0040},
         '{0,0,0,0,1, 0,0,0,0, 16'h0040},
         '{1,1,0,0,0, 0,1,0,0, 16'h0040},
         '{0,1,0,0,0, 0,0,0,0, 16'h0040}
      };

      // reset behaviour
      reset_n = 1'b0;
      bus.BR_from_dma = 1'b0; bus.cpu_mem_req = 1'b0; bus.Mem_access_done = 1'b0;
      bus.dma_end_interrupt = 1'b0; bus.interrupt_ack = 1'b0;
      bus.cpu_address = 16'h0040; bus.dma_address = 16'h0200;
      model_reset();
      repeat (3) @(negedge clk);
      check("rst bg",  32'(bus.BG_to_dma),        32'd0);
      check("rst irq", 32'(bus.interrupt_to_cpu), 32'd0);
      check("rst tmo", 32'(bus.grant_timeout),    32'd0);
      check("rst stall0", 32'(bus.cpu_stall),     32'd0);
      bus.BR_from_dma = 1'b1;
      @(posedge clk); @(negedge clk);
      check("rst stall1", 32'(bus.cpu_stall),      32'd1);
      check("rst addr",   32'(bus.address_to_mem), 32'h0040);
      check("rst bg hold", 32'(bus.BG_to_dma),     32'd0);
      bus.BR_from_dma = 1'b0;
      reset_n = 1'b1;

      // directed vector table
      for (int i = 0; i < 21; i++) begin
         step($sformatf("vec%0d", i), vecs[i].br, vecs[i].req, vecs[i].done,
              vecs[i].endi, vecs[i].ack, 16'h0040, 16'h0200);
         check($sformatf("vec%0d bg", i),    32'(bus.BG_to_dma),        32'(vecs[i].bg));
         check($sformatf("vec%0d stall", i), 32'(bus.cpu_stall),        32'(vecs[i].stall));
         check($sformatf("vec%0d irq", i),   32'(bus.interrupt_to_cpu), 32'(vecs[i].irq));
         check($sformatf("vec%0d tmo", i),   32'(bus.grant_timeout),    32'(vecs[i].to));
         check($sformatf("vec%0d addr", i),  32'(bus.address_to_mem),   32'(vecs[i].addr));
      end

      // watchdog: request held high must get exactly MAXG grant cycles and one timeout
      bg_cnt = 0; to_cnt = 0;
      for (int i = 0; i < 10; i++) begin
         step("wd", 1, 0, 0, 0, 0, 16'h0040, 16'h0200);
         bg_cnt += int'(bus.BG_to_dma);
         to_cnt += int'(bus.grant_timeout);
      end
      check("wd grant_len", 32'(bg_cnt), 32'(MAXG));
      check("wd tmo_count", 32'(to_cnt), 32'd1);
      step("wd drop", 0, 0, 0, 0, 0, 16'h0040, 16'h0200);
      check("wd unblock bg", 32'(bus.BG_to_dma), 32'd0);
      step("wd regrant", 1, 0, 0, 0, 0, 16'h0040, 16'h0200);
      check("wd regrant bg", 32'(bus.BG_to_dma), 32'd1);
      step("wd rel", 0, 0, 0, 0, 0, 16'h0040, 16'h0200);
      step("wd idle", 0, 0, 0, 0, 0, 16'h0040, 16'h0200);

      // asynchronous reset in the middle of a grant
      step("ar irq", 0, 0, 0, 1, 0, 16'h0040, 16'h0200);
      step("ar grant", 1, 0, 0, 0, 0, 16'h0040, 16'h0200);
      check("ar pre bg", 32'(bus.BG_to_dma), 32'd1);
      #2 reset_n = 1'b0;
      #1;
      check("ar bg",    32'(bus.BG_to_dma),        32'd0);
      check("ar irq0",  32'(bus.interrupt_to_cpu), 32'd0);
      check("ar stall", 32'(bus.cpu_stall),        32'd1);
      check("ar addr",  32'(bus.address_to_mem),   32'h0040);
      @(negedge clk);
      bus.BR_from_dma = 1'b0;
      reset_n = 1'b1;
      model_reset();
      step("ar idle", 0, 0, 0, 0, 0, 16'h0040, 16'h0200);
      check("ar idle stall", 32'(bus.cpu_stall), 32'd0);

      // randomized traffic against the model
      for (int i = 0; i < 400; i++) begin
         step($sformatf("rnd%0d", i),
              $urandom_range(3, 0) != 0,
              $urandom_range(1, 0) != 0,
              $urandom_range(3, 0) == 0,
              $urandom_range(2, 0) == 0,
              $urandom_range(4, 0) == 0,
              W'($urandom), W'($urandom));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
